// File: rtl/img_cap_if.sv
// rtl/img_cap_if.sv - video sync/data bundle between a frame source and the capture sink
interface img_cap_if;
    logic        img_hsync;
    logic        img_vsync;
    logic        img_de;
    logic [23:0] img_data;

    modport master (
        output img_hsync,
        output img_vsync,
        output img_de,
        output img_data
    );

    modport slave (
        input img_hsync,
        input img_vsync,
        input img_de,
        input img_data
    );
endinterface

// File: rtl/img_cap.sv
// rtl/img_cap.sv - frame sink: captures one active frame into RAM, checks geometry, sums pixels
module img_cap #(
    parameter int H_DISP = 640,
    parameter int V_DISP = 480,
    parameter int ADDR_W = 19
) (
    input  logic              clk,
    input  logic              rst,
    img_cap_if.slave          vid,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [23:0]       rd_data,
    output logic              frame_done,
    output logic [15:0]       frame_cnt,
    output logic [31:0]       frame_sum,
    output logic              err_h,
    output logic              err_v,
    output logic              err_sync
);

    localparam logic [15:0]       H_LEN  = 16'(H_DISP);
    localparam logic [15:0]       V_LEN  = 16'(V_DISP);
    localparam logic [15:0]       SAT    = 16'hFFFF;
    localparam logic [ADDR_W-1:0] H_STEP = ADDR_W'(H_DISP);

    typedef enum logic {
        WAIT_VS,
        CAPT
    } state_t;

    state_t state, state_nxt;

    logic              vs_d;
    logic              de_d;
    logic [15:0]       x;
    logic [15:0]       y;
    logic [15:0]       line_cnt;
    logic [ADDR_W-1:0] base;
    logic [31:0]       run_sum;
    logic              run_err_h;
    logic              run_err_v;
    logic              run_err_sync;

    logic              vs_fall;
    logic              de_fall;
    logic              start;
    logic              close;
    logic              active;
    logic              in_win;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic              sync_bad;
    logic              line_err;
    logic [15:0]       lines_final;
    logic              close_err_h;
    logic              close_err_v;
    logic              close_err_sync;

    logic [23:0]       mem [2**ADDR_W];

    assign vs_fall = vs_d & ~vid.img_vsync;
    assign de_fall = de_d & ~vid.img_de;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= WAIT_VS;
        end else begin
            state <= state_nxt;
        end
    end

    // A vs_fall in CAPT both closes the current frame and opens the next one.
    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        close     = 1'b0;
        active    = 1'b0;
        case (state)
            WAIT_VS: begin
                if (vs_fall) begin
                    state_nxt = CAPT;
                    start     = 1'b1;
                end
            end
            CAPT: begin
                if (vs_fall) begin
                    close = 1'b1;
                end else begin
                    active = 1'b1;
                end
            end
            default: state_nxt = WAIT_VS;
        endcase
    end

    always_comb begin
        in_win   = (x < H_LEN) && (y < V_LEN);
        wr_en    = active & vid.img_de & in_win;
        wr_addr  = base + x[ADDR_W-1:0];
        sync_bad = vid.img_de & (~vid.img_hsync | ~vid.img_vsync);
        line_err = (x != H_LEN);
        // A line still open at the frame edge is counted and length-checked before closing.
        lines_final    = (de_d && line_cnt != SAT) ? line_cnt + 16'd1 : line_cnt;
        close_err_h    = run_err_h | (de_d & line_err);
        close_err_v    = run_err_v | (lines_final != V_LEN);
        close_err_sync = run_err_sync | sync_bad;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vs_d         <= 1'b1;
            de_d         <= 1'b0;
            x            <= '0;
            y            <= '0;
            line_cnt     <= '0;
            base         <= '0;
            run_sum      <= '0;
            run_err_h    <= 1'b0;
            run_err_v    <= 1'b0;
            run_err_sync <= 1'b0;
            frame_done   <= 1'b0;
            frame_cnt    <= '0;
            frame_sum    <= '0;
            err_h        <= 1'b0;
            err_v        <= 1'b0;
            err_sync     <= 1'b0;
        end else begin
            vs_d       <= vid.img_vsync;
            de_d       <= vid.img_de;
            frame_done <= 1'b0;
            if (start || close) begin
                x            <= '0;
                y            <= '0;
                line_cnt     <= '0;
                base         <= '0;
                run_sum      <= '0;
                run_err_h    <= 1'b0;
                run_err_v    <= 1'b0;
                run_err_sync <= 1'b0;
            end
            if (close) begin
                frame_done <= 1'b1;
                frame_cnt  <= frame_cnt + 16'd1;
                frame_sum  <= run_sum;
                err_h      <= close_err_h;
                err_v      <= close_err_v;
                err_sync   <= close_err_sync;
            end else if (active) begin
                if (vid.img_de) begin
                    if (in_win) begin
                        run_sum <= run_sum + {8'd0, vid.img_data};
                    end else begin
                        if (x >= H_LEN) run_err_h <= 1'b1;
                        if (y >= V_LEN) run_err_v <= 1'b1;
                    end
                    if (x != SAT) x <= x + 16'd1;
                    if (sync_bad) run_err_sync <= 1'b1;
                end
                if (de_fall) begin
                    if (line_err) run_err_h <= 1'b1;
                    x <= '0;
                    if (y != SAT)        y        <= y + 16'd1;
                    if (line_cnt != SAT) line_cnt <= line_cnt + 16'd1;
                    // Base only matters while rows are still inside the window.
                    if (y < V_LEN)       base     <= base + H_STEP;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= vid.img_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: tb/tb_img_cap.sv
// tb/tb_img_cap.sv - directed bench for img_cap with a small 8x4 frame
module tb_img_cap;
    localparam int H  = 8;
    localparam int V  = 4;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] rd_addr;
    logic [23:0]   rd_data;
    logic          frame_done;
    logic [15:0]   frame_cnt;
    logic [31:0]   frame_sum;
    logic          err_h;
    logic          err_v;
    logic          err_sync;

    int          checks = 0;
    int          errors = 0;
    int          done_count = 0;
    logic [15:0] exp_cnt = 16'd0;
    logic [23:0] probe_old;
    logic [23:0] probe_new;
    logic [75:0] rst_snap;

    img_cap_if vid ();

    img_cap #(.H_DISP(H), .V_DISP(V), .ADDR_W(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .vid        (vid),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .frame_done (frame_done),
        .frame_cnt  (frame_cnt),
        .frame_sum  (frame_sum),
        .err_h      (err_h),
        .err_v      (err_v),
        .err_sync   (err_sync)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_done === 1'b1) done_count++;
    end

    // One frame of H_TOTAL=16 x V_TOTAL=8; active lines start at line 1, vsync low on line 7.
    task automatic drive_frame(input int nlines, input int long_line, input int sync_line,
                               input int sync_x, input int rst_line, input int rst_h,
                               input int probe_line, input int probe_x, input logic [23:0] offset);
        int rst_stage = 0;
        int probe_stage = 0;
        for (int ln = 0; ln < 8; ln++) begin
            for (int h = 0; h < 16; h++) begin
                int a;
                int px;
                int len;
                logic act;
                logic de;
                @(negedge clk);
                if (probe_stage == 2) begin
                    probe_new   = rd_data;
                    probe_stage = 0;
                end
                if (probe_stage == 1) begin
                    probe_old   = rd_data;
                    probe_stage = 2;
                end
                if (rst_stage == 1) begin
                    rst_snap  = {frame_done, frame_cnt, frame_sum, err_h, err_v, err_sync, rd_data};
                    rst_stage = 0;
                end
                a   = ln - 1;
                px  = h - 4;
                act = (ln >= 1) && (a < nlines);
                len = (a == long_line) ? 9 : 8;
                de  = act && (px >= 0) && (px < len);
                vid.img_vsync = (ln != 7);
                vid.img_hsync = (h >= 2);
                vid.img_de    = de;
                vid.img_data  = !de ? 24'd0 : (px == 8) ? 24'hFFFFFF : offset + 24'(a * 8 + px);
                if (de && a == sync_line && px == sync_x) vid.img_hsync = 1'b0;
                rst = (ln == rst_line) && (h == rst_h);
                if (rst) rst_stage = 1;
                if (de && a == probe_line && px == probe_x) begin
                    rd_addr     = AW'(a * 8 + px);
                    probe_stage = 1;
                end
            end
        end
    endtask

    task automatic clean_frame();
        drive_frame(4, -1, -1, -1, -1, -1, -1, -1, 24'd0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        vid.img_hsync = 1'b1;
        vid.img_vsync = 1'b1;
        vid.img_de    = 1'b0;
        vid.img_data  = '0;
        rd_addr       = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({frame_done, frame_cnt, frame_sum, err_h, err_v, err_sync, rd_data} !== 76'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %0h expected 0",
                     {frame_done, frame_cnt, frame_sum, err_h, err_v, err_sync, rd_data});
        end
    endtask

    task automatic test_first_sync();
        int d0 = done_count;
        for (int h = 0; h < 16; h++) begin
            @(negedge clk);
            vid.img_vsync = 1'b0;
            vid.img_hsync = (h >= 2);
            vid.img_de    = 1'b0;
        end
        @(negedge clk);
        checks++;
        if (done_count !== d0 || frame_cnt !== 16'd0) begin
            errors++;
            $display("FAIL first_sync_no_done: got done=%0d cnt=%0d expected done=%0d cnt=0",
                     done_count - d0, frame_cnt, 0);
        end
    endtask

    task automatic test_clean_frames();
        for (int f = 0; f < 2; f++) begin
            int d0 = done_count;
            clean_frame();
            exp_cnt++;
            checks++;
            if (frame_cnt !== exp_cnt || done_count - d0 !== 1) begin
                errors++;
                $display("FAIL clean_cnt: got cnt=%0d pulses=%0d expected cnt=%0d pulses=1",
                         frame_cnt, done_count - d0, exp_cnt);
            end
            checks++;
            if (frame_sum !== 32'd496 || {err_h, err_v, err_sync} !== 3'b000) begin
                errors++;
                $display("FAIL clean_sum: got sum=%0d errs=%b expected sum=496 errs=000",
                         frame_sum, {err_h, err_v, err_sync});
            end
        end
        @(negedge clk);
        rd_addr = AW'(13);
        @(negedge clk);
        checks++;
        if (rd_data !== 24'h00000D) begin
            errors++;
            $display("FAIL readback_13: got %0h expected d", rd_data);
        end
    endtask

    task automatic test_long_line();
        drive_frame(4, 2, -1, -1, -1, -1, -1, -1, 24'd0);
        exp_cnt++;
        checks++;
        if (frame_sum !== 32'd496 || {err_h, err_v, err_sync} !== 3'b100 || frame_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL long_line: got sum=%0d errs=%b cnt=%0d expected sum=496 errs=100 cnt=%0d",
                     frame_sum, {err_h, err_v, err_sync}, frame_cnt, exp_cnt);
        end
        @(negedge clk);
        rd_addr = AW'(23);
        @(negedge clk);
        checks++;
        if (rd_data !== 24'd23) begin
            errors++;
            $display("FAIL long_line_ram23: got %0h expected 17", rd_data);
        end
    endtask

    task automatic test_short_frame();
        drive_frame(3, -1, -1, -1, -1, -1, -1, -1, 24'd0);
        exp_cnt++;
        checks++;
        if (frame_sum !== 32'd276 || {err_h, err_v, err_sync} !== 3'b010) begin
            errors++;
            $display("FAIL short_frame: got sum=%0d errs=%b expected sum=276 errs=010",
                     frame_sum, {err_h, err_v, err_sync});
        end
    endtask

    task automatic test_sync_error();
        drive_frame(4, -1, 1, 3, -1, -1, -1, -1, 24'd0);
        exp_cnt++;
        checks++;
        if (frame_sum !== 32'd496 || {err_h, err_v, err_sync} !== 3'b001) begin
            errors++;
            $display("FAIL sync_error: got sum=%0d errs=%b expected sum=496 errs=001",
                     frame_sum, {err_h, err_v, err_sync});
        end
        clean_frame();
        exp_cnt++;
        checks++;
        if ({err_h, err_v, err_sync} !== 3'b000 || frame_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL sync_error_clear: got errs=%b cnt=%0d expected errs=000 cnt=%0d",
                     {err_h, err_v, err_sync}, frame_cnt, exp_cnt);
        end
    endtask

    task automatic test_rw_collision();
        drive_frame(4, -1, -1, -1, -1, -1, 0, 5, 24'h000100);
        exp_cnt++;
        checks++;
        if (probe_old !== 24'h000005) begin
            errors++;
            $display("FAIL rw_old_data: got %0h expected 5", probe_old);
        end
        checks++;
        if (probe_new !== 24'h000105) begin
            errors++;
            $display("FAIL rw_new_data: got %0h expected 105", probe_new);
        end
        checks++;
        if (frame_sum !== 32'd8688) begin
            errors++;
            $display("FAIL rw_sum: got %0d expected 8688", frame_sum);
        end
    endtask

    task automatic test_reset_mid_frame();
        int d0 = done_count;
        drive_frame(4, -1, -1, -1, 2, 6, -1, -1, 24'd0);
        exp_cnt = 16'd0;
        checks++;
        if (rst_snap !== 76'd0) begin
            errors++;
            $display("FAIL mid_reset_outputs: got %0h expected 0", rst_snap);
        end
        checks++;
        if (done_count !== d0 || frame_cnt !== 16'd0) begin
            errors++;
            $display("FAIL mid_reset_no_done: got pulses=%0d cnt=%0d expected pulses=0 cnt=0",
                     done_count - d0, frame_cnt);
        end
        d0 = done_count;
        clean_frame();
        exp_cnt++;
        checks++;
        if (frame_cnt !== exp_cnt || done_count - d0 !== 1 || frame_sum !== 32'd496 ||
            {err_h, err_v, err_sync} !== 3'b000) begin
            errors++;
            $display("FAIL mid_reset_recover: got cnt=%0d pulses=%0d sum=%0d errs=%b expected cnt=1 pulses=1 sum=496 errs=000",
                     frame_cnt, done_count - d0, frame_sum, {err_h, err_v, err_sync});
        end
    endtask

    initial begin
        test_reset();
        test_first_sync();
        test_clean_frames();
        test_long_line();
        test_short_frame();
        test_sync_error();
        test_rw_collision();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
